// File: rtl/rh_hammer_ctrl.sv
// rh_hammer_ctrl: sequences one double-sided Rowhammer experiment on a level-handshake command port.
// Build option FIRST_FLIP_CAPTURE_EN adds capture of the first flipped word seen during CHECK.
module rh_hammer_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int ROW_WIDTH  = 12,
    parameter int ROW_POS    = 10,
    parameter int COL_WIDTH  = 10,
    parameter int COL_POS    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROW_WIDTH-1:0]  victim_row,
    input  logic [WORD_WIDTH-1:0] pattern,
    input  logic [31:0]           hammer_count,
    input  logic                  confirm,
    input  logic [WORD_WIDTH-1:0] rd_data,
    output logic                  write,
    output logic                  read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] wr_data,
    output logic [3:0]            state,
    output logic                  busy,
    output logic                  done,
    output logic [63:0]           flip_count
`ifdef FIRST_FLIP_CAPTURE_EN
    ,
    output logic                  first_flip_valid,
    output logic [ADDR_WIDTH-1:0] first_flip_addr,
    output logic [WORD_WIDTH-1:0] first_flip_mask
`endif
);
    // state  | meaning
    // IDLE   | waiting for start
    // FILL_V | writing pattern across every column of the victim row
    // FILL_A | writing ~pattern to column 0 of each existing aggressor
    // HAMMER | alternating aggressor reads, hammer_count iterations
    // CHECK  | reading the victim row back and counting flipped bits
    // DONE   | result held until the next start
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FILL_V = 4'd1,
        S_FILL_A = 4'd2,
        S_HAMMER = 4'd3,
        S_CHECK  = 4'd4,
        S_DONE   = 4'd5
    } state_t;

    typedef enum logic [1:0] {C_SLOT, C_ACK, C_REL} cmd_phase_t;

    localparam int PW = $clog2(WORD_WIDTH + 1);
    localparam logic [ROW_WIDTH-1:0] ROW_MAX = '1;
    localparam logic [COL_WIDTH-1:0] COL_MAX = '1;

    state_t                st;
    cmd_phase_t            cph;
    logic [ROW_WIDTH-1:0]  vic_q;
    logic [WORD_WIDTH-1:0] pat_q;
    logic [31:0]           hc_q;
    logic [31:0]           iter_q;
    logic [COL_WIDTH-1:0]  col_q;
    logic                  hi_side;

    logic                  has_lo;
    logic                  has_hi;
    logic                  last_side;
    logic                  start_ok;
    logic [ROW_WIDTH-1:0]  row_sel;
    logic [COL_WIDTH-1:0]  col_sel;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [WORD_WIDTH-1:0] diff;
    logic [PW-1:0]         pop;
    logic [64:0]           sum;
    logic [63:0]           flip_next;

    assign has_lo    = (vic_q != '0);
    assign has_hi    = (vic_q != ROW_MAX);
    assign last_side = hi_side || !has_hi;
    assign start_ok  = start && (st == S_IDLE || st == S_DONE);

    assign state = st;
    assign busy  = (st != S_IDLE) && (st != S_DONE);
    assign done  = (st == S_DONE);

    // Aggressor phases always target column 0 of victim-1 / victim+1.
    always_comb begin
        row_sel = vic_q;
        col_sel = col_q;
        if (st == S_FILL_A || st == S_HAMMER) begin
            row_sel = hi_side ? vic_q + 1'b1 : vic_q - 1'b1;
            col_sel = '0;
        end
    end

    assign cmd_addr = (ADDR_WIDTH'(row_sel) << ROW_POS) | (ADDR_WIDTH'(col_sel) << COL_POS);

    assign diff = rd_data ^ pat_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            pop = pop + PW'(diff[i]);
        end
    end

    assign sum       = {1'b0, flip_count} + 65'(pop);
    assign flip_next = sum[64] ? '1 : sum[63:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= S_IDLE;
            cph        <= C_SLOT;
            vic_q      <= '0;
            pat_q      <= '0;
            hc_q       <= '0;
            iter_q     <= '0;
            col_q      <= '0;
            hi_side    <= 1'b0;
            write      <= 1'b0;
            read       <= 1'b0;
            address    <= '0;
            wr_data    <= '0;
            flip_count <= '0;
`ifdef FIRST_FLIP_CAPTURE_EN
            first_flip_valid <= 1'b0;
            first_flip_addr  <= '0;
            first_flip_mask  <= '0;
`endif
        end else if (start_ok) begin
            st         <= S_FILL_V;
            cph        <= C_SLOT;
            vic_q      <= victim_row;
            pat_q      <= pattern;
            hc_q       <= hammer_count;
            iter_q     <= '0;
            col_q      <= '0;
            hi_side    <= 1'b0;
            flip_count <= '0;
`ifdef FIRST_FLIP_CAPTURE_EN
            first_flip_valid <= 1'b0;
            first_flip_addr  <= '0;
            first_flip_mask  <= '0;
`endif
        end else if (busy) begin
            case (cph)
                C_SLOT: begin
                    address <= cmd_addr;
                    cph     <= C_ACK;
                    if (st == S_FILL_V || st == S_FILL_A) begin
                        write   <= 1'b1;
                        wr_data <= (st == S_FILL_V) ? pat_q : ~pat_q;
                    end else begin
                        read <= 1'b1;
                    end
                end
                C_ACK: begin
                    if (confirm) begin
                        write <= 1'b0;
                        read  <= 1'b0;
                        cph   <= C_REL;
                        if (st == S_CHECK) begin
                            flip_count <= flip_next;
`ifdef FIRST_FLIP_CAPTURE_EN
                            if (!first_flip_valid && diff != '0) begin
                                first_flip_valid <= 1'b1;
                                first_flip_addr  <= address;
                                first_flip_mask  <= diff;
                            end
`endif
                        end
                    end
                end
                C_REL: begin
                    // Advance only once confirm has dropped, so a long confirm counts once.
                    if (!confirm) begin
                        cph <= C_SLOT;
                        case (st)
                            S_FILL_V: begin
                                if (col_q == COL_MAX) begin
                                    st      <= S_FILL_A;
                                    col_q   <= '0;
                                    hi_side <= !has_lo;
                                end else begin
                                    col_q <= col_q + 1'b1;
                                end
                            end
                            S_FILL_A: begin
                                if (!last_side) begin
                                    hi_side <= 1'b1;
                                end else begin
                                    hi_side <= !has_lo;
                                    st      <= (hc_q == 32'd0) ? S_CHECK : S_HAMMER;
                                end
                            end
                            S_HAMMER: begin
                                if (!last_side) begin
                                    hi_side <= 1'b1;
                                end else begin
                                    hi_side <= !has_lo;
                                    if (iter_q + 32'd1 == hc_q) begin
                                        st <= S_CHECK;
                                    end else begin
                                        iter_q <= iter_q + 32'd1;
                                    end
                                end
                            end
                            S_CHECK: begin
                                if (col_q == COL_MAX) begin
                                    st <= S_DONE;
                                end else begin
                                    col_q <= col_q + 1'b1;
                                end
                            end
                            default: begin
                                st <= st;
                            end
                        endcase
                    end
                end
                default: begin
                    cph <= C_SLOT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rh_hammer_ctrl.sv
// Scoreboard bench for rh_hammer_ctrl: reference command stream queued per experiment, memory-model monitor pops and compares.
module tb_rh_hammer_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] victim_row;
    logic [31:0] pattern;
    logic [31:0] hammer_count;
    logic        confirm;
    logic [31:0] rd_data;
    logic        write;
    logic        read;
    logic [31:0] address;
    logic [31:0] wr_data;
    logic [3:0]  state;
    logic        busy;
    logic        done;
    logic [63:0] flip_count;
`ifdef FIRST_FLIP_CAPTURE_EN
    logic        first_flip_valid;
    logic [31:0] first_flip_addr;
    logic [31:0] first_flip_mask;
`endif

    rh_hammer_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .victim_row(victim_row),
        .pattern(pattern), .hammer_count(hammer_count), .confirm(confirm),
        .rd_data(rd_data), .write(write), .read(read), .address(address),
        .wr_data(wr_data), .state(state), .busy(busy), .done(done),
        .flip_count(flip_count)
`ifdef FIRST_FLIP_CAPTURE_EN
        , .first_flip_valid(first_flip_valid), .first_flip_addr(first_flip_addr),
        .first_flip_mask(first_flip_mask)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_s;

    cmd_s        exp_q[$];
    logic [31:0] mem[bit [31:0]];
    logic [31:0] flip[bit [31:0]];

    int checks = 0;
    int passes = 0;

    int          m_hold = 1, m_dmin = 1, m_dmax = 1;
    int          mst = 0, cnt = 0, hcnt = 0;
    logic        cur_wr;
    logic [31:0] cur_addr, cur_data;
    int          cmds_seen, hold_err, exp_n;
    bit          seen_hammer;
    longint      exp_flips;
    bit          exp_ff_valid;
    logic [31:0] exp_ff_addr, exp_ff_mask;

    task automatic check(string name, logic [127:0] act, logic [127:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic logic [31:0] mk_addr(int row, int col);
        return 32'((row << 10) | col);
    endfunction

    // Expected command stream straight from the experiment description.
    task automatic build_expected(int v, logic [31:0] p, int hc);
        bit lo = (v > 0);
        bit hi = (v < 4095);
        exp_q.delete();
        for (int c = 0; c < 1024; c++) exp_q.push_back('{1'b1, mk_addr(v, c), p});
        if (lo) exp_q.push_back('{1'b1, mk_addr(v - 1, 0), ~p});
        if (hi) exp_q.push_back('{1'b1, mk_addr(v + 1, 0), ~p});
        for (int i = 0; i < hc; i++) begin
            if (lo) exp_q.push_back('{1'b0, mk_addr(v - 1, 0), 32'h0});
            if (hi) exp_q.push_back('{1'b0, mk_addr(v + 1, 0), 32'h0});
        end
        for (int c = 0; c < 1024; c++) exp_q.push_back('{1'b0, mk_addr(v, c), 32'h0});
        exp_n = exp_q.size();
        exp_flips = 0;
        exp_ff_valid = 1'b0;
        exp_ff_addr = '0;
        exp_ff_mask = '0;
        for (int c = 0; c < 1024; c++) begin
            if (flip.exists(mk_addr(v, c))) begin
                exp_flips += $countones(flip[mk_addr(v, c)]);
                if (!exp_ff_valid && flip[mk_addr(v, c)] != 0) begin
                    exp_ff_valid = 1'b1;
                    exp_ff_addr  = mk_addr(v, c);
                    exp_ff_mask  = flip[mk_addr(v, c)];
                end
            end
        end
    endtask

    // Memory model and monitor: accepts a command, compares against the scoreboard, confirms after a delay.
    always @(negedge clk) begin
        if (reset) begin
            mst = 0;
            confirm = 1'b0;
            rd_data = '0;
        end else begin
            case (mst)
                0: if (write || read) begin
                    cmd_s e;
                    cmds_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_cmd", {write, read, address}, 128'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd", {write, read, address, write ? wr_data : 32'h0},
                              {e.is_wr, !e.is_wr, e.addr, e.is_wr ? e.data : 32'h0});
                    end
                    cur_wr = write;
                    cur_addr = address;
                    cur_data = wr_data;
                    cnt = $urandom_range(m_dmax, m_dmin);
                    mst = 1;
                end
                1: begin
                    if (!(write || read)) hold_err++;
                    cnt--;
                    if (cnt == 0) begin
                        logic [31:0] v;
                        v = mem.exists(cur_addr) ? mem[cur_addr] : 32'h0;
                        if (flip.exists(cur_addr)) v = v ^ flip[cur_addr];
                        rd_data = cur_wr ? 32'h0 : v;
                        if (cur_wr) mem[cur_addr] = cur_data;
                        confirm = 1'b1;
                        hcnt = m_hold;
                        mst = 2;
                    end
                end
                default: begin
                    hcnt--;
                    if (hcnt == 0) begin
                        confirm = 1'b0;
                        rd_data = '0;
                        mst = 0;
                    end
                end
            endcase
            if (state == 4'd3) seen_hammer = 1'b1;
        end
    end

    task automatic begin_exp(int v, logic [31:0] p, int hc, int hold, int dmin, int dmax);
        mem.delete();
        build_expected(v, p, hc);
        cmds_seen = 0;
        hold_err = 0;
        seen_hammer = 1'b0;
        m_hold = hold;
        m_dmin = dmin;
        m_dmax = dmax;
        @(negedge clk);
        victim_row = 12'(v);
        pattern = p;
        hammer_count = 32'(hc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {busy, state}, {1'b1, 4'd1});
        victim_row = 12'($urandom);
        pattern = $urandom;
        hammer_count = $urandom;
    endtask

    task automatic finish_exp(string tag, int hc, bit poke);
        int cyc = 0;
        if (poke) begin
            repeat (60) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (!done && cyc < 60000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, {done, busy, state}, {1'b1, 1'b0, 4'd5});
        check({tag, "_flips"}, flip_count, exp_flips);
        check({tag, "_cmd_total"}, cmds_seen, exp_n);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_req_held"}, hold_err, 0);
        check({tag, "_hammer_seen"}, seen_hammer, hc != 0);
`ifdef FIRST_FLIP_CAPTURE_EN
        check({tag, "_first_flip"}, {first_flip_valid, first_flip_addr, first_flip_mask},
              {exp_ff_valid, exp_ff_valid ? exp_ff_addr : 32'h0, exp_ff_valid ? exp_ff_mask : 32'h0});
`endif
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b0;
        victim_row = '0;
        pattern = '0;
        hammer_count = '0;
        confirm = 1'b0;
        rd_data = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {write, read, busy, done, state, flip_count, address, wr_data},
              {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 32'd0, 32'd0});
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {busy, done, state}, {1'b0, 1'b0, 4'd0});

        // Clean memory, pattern all ones.
        flip.delete();
        begin_exp(5, 32'hFFFF_FFFF, 100, 1, 1, 1);
        finish_exp("clean", 100, 1'b0);

        // Two corrupted victim words: 3 bits at col 7, 1 bit at col 900.
        flip.delete();
        flip[mk_addr(5, 7)]   = 32'h0000_0007;
        flip[mk_addr(5, 900)] = 32'h8000_0000;
        begin_exp(5, 32'hFFFF_FFFF, 100, 1, 1, 1);
        finish_exp("flips", 100, 1'b0);

        // Edge row 0, single aggressor; a start while busy must be ignored.
        flip.delete();
        begin_exp(0, $urandom, 50, 1, 1, 3);
        finish_exp("row0", 50, 1'b1);

        // Top row, no hammering, random corruption.
        flip.delete();
        for (int k = 0; k < 3; k++) flip[mk_addr(4095, $urandom_range(1023, 0))] = $urandom | 32'h1;
        begin_exp(4095, $urandom, 0, 1, 1, 2);
        finish_exp("rowmax_h0", 0, 1'b0);

        // Asynchronous reset while a hammer read is outstanding.
        flip.delete();
        begin_exp(5, 32'hFFFF_FFFF, 100, 1, 2, 4);
        cyc = 0;
        while (!(state == 4'd3 && read) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_hammer_read", {state, read}, {4'd3, 1'b1});
        #2 reset = 1'b1;
        #1 check("async_reset", {write, read, busy, done, state, flip_count},
                 {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0});
        repeat (2) @(negedge clk);
        exp_q.delete();
        mem.delete();
        reset = 1'b0;
        @(negedge clk);

        // Two-cycle confirm pulses with random latency after the reset.
        flip.delete();
        flip[mk_addr(5, $urandom_range(1023, 0))] = $urandom | 32'h10;
        flip[mk_addr(5, $urandom_range(1023, 0))] = $urandom | 32'h1;
        begin_exp(5, 32'hFFFF_FFFF, 100, 2, 1, 10);
        finish_exp("long_confirm", 100, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/rh_hammer_ctrl.md
Name: rh_hammer_ctrl

Overview:
Sequencer for one double-sided Rowhammer experiment against a single victim row, using the team's level-handshake memory command port (write/read held until confirm).
- Fills the victim row with a pattern and the aggressor rows with its complement, then hammers the aggressors alternately.
- Reads the victim row back and accumulates the count of flipped bits.
- Sits between the host/experiment register block and the memory command port; it is the campaign-level controller for the bit-flip checking datapath.

Parameters:
ADDR_WIDTH, 32, memory address width in bits
WORD_WIDTH, 32, data word width in bits
ROW_WIDTH, 12, row field width in address
ROW_POS, 10, LSB position of row field
COL_WIDTH, 10, column field width in address
COL_POS, 0, LSB position of column field

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  begin experiment; sampled only in IDLE or DONE
victim_row  in  ROW_WIDTH  victim row index; latched on start
pattern  in  WORD_WIDTH  victim fill pattern; latched on start
hammer_count  in  32  hammer iterations; latched on start
confirm  in  1  memory completed current command (level)
rd_data  in  WORD_WIDTH  read-back word; valid while confirm high on a read
write  out  1  write command request
read  out  1  read command request
address  out  ADDR_WIDTH  command address
wr_data  out  WORD_WIDTH  write data
state  out  4  current phase encoding
busy  out  1  high in any state other than IDLE and DONE
done  out  1  high in DONE
flip_count  out  64  accumulated flipped bits

Behaviour:
- Reset: all outputs 0; state=IDLE (0); internal counters 0. Asynchronous; takes effect immediately mid-command, including forcing write/read low.
- State encoding: IDLE=0, FILL_V=1, FILL_A=2, HAMMER=3, CHECK=4, DONE=5.
- Address composition: row<<ROW_POS | col<<COL_POS; all other bits 0.
- Command handshake:
  - write/read rise the cycle after entering a command slot and hold until confirm is sampled high.
  - Drop on the next edge.
  - Next command is issued only after confirm is sampled low (release wait). A multi-cycle confirm pulse therefore counts as exactly one completion.
- IDLE/DONE + start: latch inputs, clear flip_count, go to FILL_V.
- start while busy is ignored.
- FILL_V: write pattern to victim row, columns 0..2^COL_WIDTH-1 ascending, then go to FILL_A.
- FILL_A: write ~pattern to column 0 of each existing aggressor (victim-1, then victim+1).
  - victim_row=0: aggressor row 1 only.
  - victim_row=2^ROW_WIDTH-1: aggressor victim-1 only.
- HAMMER:
  - Double-sided: each iteration reads col 0 of victim-1, then col 0 of victim+1. Total reads = 2*hammer_count.
  - Single-sided (edge row): one read per iteration, hammer_count total.
  - rd_data is ignored.
  - hammer_count=0: skip straight to CHECK with no reads.
- CHECK:
  - Read victim row, columns 0..max ascending.
  - On each confirm-high sample, flip_count += popcount(rd_data ^ pattern); saturate at all-ones.
  - After the last column, go to DONE.
- DONE holds flip_count until the next start or reset.
- Iteration counter is 32-bit and does not wrap; compare is against the latched hammer_count.

Optional Feature:
Macro: FIRST_FLIP_CAPTURE_EN
- Defined: adds outputs first_flip_valid (1), first_flip_addr (ADDR_WIDTH) and first_flip_mask (WORD_WIDTH).
  - On the first CHECK read with nonzero rd_data^pattern, capture the address and XOR mask and set valid.
  - Later flips do not overwrite the capture.
  - All three clear on reset and on an accepted start.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
1. victim_row=5, pattern=FFFFFFFF, hammer_count=100, clean memory model -> 1024 writes to row 5 with FFFFFFFF; writes row4/col0 then row6/col0 with 00000000; 200 reads alternating row4,row6 col0; 1024 reads of row 5; done=1, state=5, flip_count=0.
2. Same as 1, model returns FFFFFFF8 at row5 col7 and 7FFFFFFF at col900 -> flip_count=4.
3. victim_row=0, hammer_count=50 -> FILL_A writes only row1 col0; HAMMER issues exactly 50 reads of row1 col0; check completes.
4. hammer_count=0 -> no reads issued between the last FILL_A write and the first CHECK read; state goes 2->4.
5. Reset asserted mid-HAMMER while read is high -> write/read/busy/flip_count drop in the same cycle, state=0; a subsequent start runs a complete experiment correctly.
6. confirm held high for 2 cycles on every command, random 1-10 cycle delay -> exactly one address advance per command; total command count matches case 1.
